// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 serial decoder: FSM states,
// counter widths, default glitch length and saturating increment helpers.
package ws2812_pkg;

  localparam int HIGH_CNT_W            = 8;
  localparam int LOW_CNT_W             = 16;
  localparam int BYTE_IDX_W            = 8;
  localparam int GLITCH_CYCLES_DEFAULT = 3;

  typedef logic [HIGH_CNT_W-1:0] high_cnt_t;
  typedef logic [LOW_CNT_W-1:0]  low_cnt_t;
  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  function automatic high_cnt_t sat_inc_high(input high_cnt_t v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  function automatic low_cnt_t sat_inc_low(input low_cnt_t v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line plus rise/fall
// detection on the synchronized level.
module ws2812_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic async_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_out = sync_q;
  assign rise_out  = sync_q & ~prev_q;
  assign fall_out  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_decode.sv
// WS2812 serial decoder: measures high pulses, assembles MSB-first bytes and
// writes them into a 64x32 byte-lane memory interface; a long low ends the frame.
// Optional high-pulse glitch filter enabled by WS2812_DECODE_GLITCH_FILTER_EN.
module ws2812_decode
  import ws2812_pkg::*;
#(
  parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ws2812_code_in,
  input  logic [7:0]  bit_th_cnt_in,
  input  logic [15:0] rst_cnt_in,
  output logic        wr_en_out,
  output logic [5:0]  wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic [3:0]  wr_byte_en_out,
  output logic        wr_done_out,
  output logic        ovf_out
);

`ifdef WS2812_DECODE_GLITCH_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif
  localparam high_cnt_t GLITCH_TH = high_cnt_t'(GLITCH_CYCLES);

  logic line_s, rise_s, fall_s;

  ws2812_sync u_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .async_in  (ws2812_code_in),
    .level_out (line_s),
    .rise_out  (rise_s),
    .fall_out  (fall_s)
  );

  state_e    state_q, state_d;
  low_cnt_t  low_cnt_q, low_cnt_d;
  high_cnt_t high_cnt_q, high_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  byte_idx_t byte_idx_q, byte_idx_d;
  logic      full_q, full_d;
  logic      any_bit_q, any_bit_d;
  logic      ovf_q, ovf_d;
  logic      wr_en_q, wr_en_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [3:0] wr_be_q, wr_be_d;
  logic      wr_done_q, wr_done_d;

  low_cnt_t   rst_th_s;
  logic       sync_done_s;
  logic       glitch_s;
  logic       bit_val_s;
  logic [7:0] byte_s;

  // A zero end-of-frame length would never match a running count, so clamp to 1.
  assign rst_th_s    = (rst_cnt_in == 16'd0) ? 16'd1 : rst_cnt_in;
  assign sync_done_s = !line_s && (sat_inc_low(low_cnt_q) >= rst_th_s);
  assign glitch_s    = FILTER_EN && (high_cnt_q < GLITCH_TH);
  assign bit_val_s   = (high_cnt_q >= bit_th_cnt_in);
  assign byte_s      = {shift_q[6:0], bit_val_s};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: state_d = sync_done_s ? ST_LOW : ST_SYNC;
      ST_LOW:  state_d = rise_s ? ST_HIGH : ST_LOW;
      ST_HIGH: state_d = fall_s ? ST_LOW : ST_HIGH;
      default: state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    full_d     = full_q;
    any_bit_d  = any_bit_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = 6'd0;
    wr_data_d  = 8'd0;
    wr_be_d    = 4'd0;
    wr_done_d  = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (line_s) begin
          low_cnt_d = 16'd0;
        end else begin
          low_cnt_d = sat_inc_low(low_cnt_q);
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          high_cnt_d = 8'd1;
        end else begin
          low_cnt_d = sat_inc_low(low_cnt_q);
          if (low_cnt_q == rst_th_s) begin
            wr_done_d  = any_bit_q;
            shift_d    = 8'd0;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 8'd0;
            full_d     = 1'b0;
            any_bit_d  = 1'b0;
            ovf_d      = 1'b0;
          end else begin
            wr_done_d = 1'b0;
          end
        end
      end
      ST_HIGH: begin
        high_cnt_d = sat_inc_high(high_cnt_q);
        // With filtering, the low time keeps running so a rejected spike is invisible.
        if (FILTER_EN) begin
          low_cnt_d = sat_inc_low(low_cnt_q);
        end else begin
          low_cnt_d = low_cnt_q;
        end
        if (fall_s && !glitch_s) begin
          low_cnt_d = 16'd1;
          shift_d   = byte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          any_bit_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            if (full_q) begin
              ovf_d = 1'b1;
            end else begin
              wr_en_d    = 1'b1;
              wr_addr_d  = byte_idx_q[7:2];
              wr_data_d  = byte_s;
              wr_be_d    = 4'b0001 << byte_idx_q[1:0];
              byte_idx_d = byte_idx_q + 8'd1;
              full_d     = (byte_idx_q == 8'hFF);
            end
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          shift_d = shift_q;
        end
      end
      default: begin
        low_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      low_cnt_q  <= 16'd0;
      high_cnt_q <= 8'd0;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 8'd0;
      full_q     <= 1'b0;
      any_bit_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= 8'd0;
      wr_be_q    <= 4'd0;
      wr_done_q  <= 1'b0;
    end else begin
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      full_q     <= full_d;
      any_bit_q  <= any_bit_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign wr_byte_en_out = wr_be_q;
  assign wr_done_out    = wr_done_q;
  assign ovf_out        = ovf_q;

endmodule

// File: tb/tb_ws2812_decode.sv
// Self-checking bench for ws2812_decode: table of frames plus hand sequences
// for glitch spikes and mid-frame reset; writes checked through a scoreboard.
module tb_ws2812_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ws = 1'b0;
  logic [7:0]  th = 8'd35;
  logic [15:0] rstc = 16'd50;
  logic        wr_en_out, wr_done_out, ovf_out;
  logic [5:0]  wr_addr_out;
  logic [7:0]  wr_data_out;
  logic [3:0]  wr_byte_en_out;

  ws2812_decode dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ws2812_code_in (ws),
    .bit_th_cnt_in  (th),
    .rst_cnt_in     (rstc),
    .wr_en_out      (wr_en_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .wr_byte_en_out (wr_byte_en_out),
    .wr_done_out    (wr_done_out),
    .ovf_out        (ovf_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int done_cnt = 0;
  int t0 = 20, t1 = 50, tlow = 25;
  logic [17:0] exp_q[$];
  logic [17:0] exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en_out) begin
      wr_seen++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("write_addr_be_data", 32'({wr_addr_out, wr_byte_en_out, wr_data_out}), 32'(exp_e));
      end
    end
    if (wr_done_out) begin
      done_cnt++;
      check("done_without_wr_en", 32'(wr_en_out), 32'd0);
      check("ovf_clear_at_done", 32'(ovf_out), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic hold(input logic v, input int n);
    ws = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? t1 : t0);
    hold(1'b0, tlow);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic expect_write(input int k, input logic [7:0] v);
    logic [3:0] be;
    be = 4'b0001 << (k % 4);
    exp_q.push_back({6'(k / 4), be, v});
  endtask

  typedef struct {
    int t0, t1, tlow, th, rstc, nbytes, extra;
    logic [7:0] first;
    int exp_wr, exp_done;
    logic exp_ovf;
  } vec_t;

  vec_t vecs[7];
  int w0, d0;
  logic [7:0] glitch_byte;

  initial begin
    vecs[0] = '{20, 50, 25, 35, 50, 1,   0, 8'hA5, 1,   1, 1'b0};
    vecs[1] = '{20, 50, 25, 35, 50, 6,   0, 8'h00, 6,   1, 1'b0};
    vecs[2] = '{20, 50, 25, 35, 50, 3,   5, 8'h10, 3,   1, 1'b0};
    vecs[3] = '{20, 50, 25, 35, 50, 1,   0, 8'hC3, 1,   1, 1'b0};
    vecs[4] = '{3,  7,  3,  5,  0,  0,   1, 8'h00, 0,   1, 1'b0};
    vecs[5] = '{3,  7,  3,  5,  50, 257, 0, 8'h00, 256, 1, 1'b1};
    vecs[6] = '{3,  7,  3,  5,  50, 2,   0, 8'hE0, 2,   1, 1'b0};

    repeat (5) @(negedge clk);
    check("reset_outputs", 32'({wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out, wr_done_out, ovf_out}), 32'd0);
    rst = 1'b0;
    hold(1'b0, 100);

    for (int r = 0; r < 7; r++) begin
      t0 = vecs[r].t0; t1 = vecs[r].t1; tlow = vecs[r].tlow;
      th = 8'(vecs[r].th); rstc = 16'(vecs[r].rstc);
      hold(1'b0, 200);
      w0 = wr_seen; d0 = done_cnt;
      for (int k = 0; k < vecs[r].nbytes; k++) begin
        if (k < 256) expect_write(k, 8'(vecs[r].first + 8'(k)));
        send_byte(8'(vecs[r].first + 8'(k)));
      end
      for (int e = 0; e < vecs[r].extra; e++) send_bit(1'b1);
      check($sformatf("row%0d_ovf_before_end", r), 32'(ovf_out), 32'(vecs[r].exp_ovf));
      hold(1'b0, 120);
      check($sformatf("row%0d_writes", r), 32'(wr_seen - w0), 32'(vecs[r].exp_wr));
      check($sformatf("row%0d_dones", r), 32'(done_cnt - d0), 32'(vecs[r].exp_done));
      check($sformatf("row%0d_queue_left", r), 32'(exp_q.size()), 32'd0);
      check($sformatf("row%0d_ovf_after_end", r), 32'(ovf_out), 32'd0);
    end

    // Short high spike between the 7th and 8th bit of 0xA5.
    t0 = 20; t1 = 50; tlow = 25; th = 8'd35; rstc = 16'd50;
    hold(1'b0, 200);
`ifdef WS2812_DECODE_GLITCH_FILTER_EN
    glitch_byte = 8'hA5;
`else
    glitch_byte = 8'hA4;
`endif
    w0 = wr_seen; d0 = done_cnt;
    expect_write(0, glitch_byte);
    for (int i = 7; i >= 2; i--) send_bit(glitch_byte[i]);
    hold(1'b1, t0);
    hold(1'b0, 10);
    hold(1'b1, 2);
    hold(1'b0, 10);
    send_bit(1'b1);
    hold(1'b0, 120);
    check("glitch_writes", 32'(wr_seen - w0), 32'd1);
    check("glitch_dones", 32'(done_cnt - d0), 32'd1);
    check("glitch_queue_left", 32'(exp_q.size()), 32'd0);

    // Reset after 12 bits: the completed byte is written, the rest discarded.
    hold(1'b0, 200);
    w0 = wr_seen; d0 = done_cnt;
    expect_write(0, 8'h96);
    send_byte(8'h96);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_outputs", 32'({wr_en_out, wr_addr_out, wr_data_out, wr_byte_en_out, wr_done_out, ovf_out}), 32'd0);
    rst = 1'b0;
    hold(1'b0, 120);
    check("midreset_writes", 32'(wr_seen - w0), 32'd1);
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    expect_write(0, 8'h3C);
    send_byte(8'h3C);
    hold(1'b0, 120);
    check("after_reset_writes", 32'(wr_seen - w0), 32'd2);
    check("after_reset_done", 32'(done_cnt - d0), 32'd1);
    check("after_reset_queue_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
